// File: rtl/mc_controller.sv
// Multicycle main control FSM for the 16-bit RISC core.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath.
module mc_controller #(
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            irwrite,
    output logic            pcen,
    output logic            regwrite,
    output logic            memwrite,
    output logic            iord,
    output logic            memtoreg,
    output logic            regdst,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic [1:0]      aluop,
    output logic            illegal,
    output logic [3:0]      state
);

    localparam logic [OP_W-1:0] op_r    = OP_W'(0);
    localparam logic [OP_W-1:0] op_lw   = OP_W'(1);
    localparam logic [OP_W-1:0] op_sw   = OP_W'(2);
    localparam logic [OP_W-1:0] op_beq  = OP_W'(3);
    localparam logic [OP_W-1:0] op_addi = OP_W'(4);
    localparam logic [OP_W-1:0] op_slti = OP_W'(5);
    localparam logic [OP_W-1:0] op_j    = OP_W'(6);

    typedef enum logic [3:0] {
        s_fetch   = 4'd0,
        s_decode  = 4'd1,
        s_memadr  = 4'd2,
        s_memrd   = 4'd3,
        s_memwb   = 4'd4,
        s_memwr   = 4'd5,
        s_execute = 4'd6,
        s_aluwb   = 4'd7,
        s_branch  = 4'd8,
        s_addiex  = 4'd9,
        s_sltiex  = 4'd10,
        s_iwb     = 4'd11,
        s_jump    = 4'd12
    } state_t;

    state_t cur, nxt;
    logic   pcwrite;
    logic   branch;

    assign state = cur;

    // State register; reset always returns the FSM to fetch.
    always_ff @(posedge clk) begin
        if (reset) cur <= s_fetch;
        else       cur <= nxt;
    end

    // Next-state and output decode; every output is quiet during reset.
    always_comb begin
        nxt      = s_fetch;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b11;
        illegal  = 1'b0;
        if (reset) begin
            aluop = 2'b00;
        end else begin
            unique case (cur)
                s_fetch: begin
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                    nxt     = mem_ready ? s_decode : s_fetch;
                end
                s_decode: begin
                    alusrcb = 2'b11;
                    if (opcode == op_lw || opcode == op_sw) nxt = s_memadr;
                    else if (opcode == op_r)    nxt = s_execute;
                    else if (opcode == op_beq)  nxt = s_branch;
                    else if (opcode == op_addi) nxt = s_addiex;
                    else if (opcode == op_slti) nxt = s_sltiex;
                    else if (opcode == op_j)    nxt = s_jump;
                    else                        illegal = 1'b1;
                end
                s_memadr: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    if (opcode == op_lw)      nxt = s_memrd;
                    else if (opcode == op_sw) nxt = s_memwr;
                end
                s_memrd: begin
                    iord = 1'b1;
                    nxt  = mem_ready ? s_memwb : s_memrd;
                end
                s_memwb: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                s_memwr: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    nxt      = mem_ready ? s_fetch : s_memwr;
                end
                s_execute: begin
                    alusrca = 1'b1;
                    aluop   = 2'b00;
                    nxt     = s_aluwb;
                end
                s_aluwb: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                s_branch: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                s_addiex: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    nxt     = s_iwb;
                end
                s_sltiex: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = 2'b01;
                    nxt     = s_iwb;
                end
                s_iwb: begin
                    regwrite = 1'b1;
                end
                s_jump: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: begin
                    aluop = 2'b00;
                end
            endcase
        end
        pcen = pcwrite | (branch & zero);
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed per-cycle vectors.
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       irwrite, pcen, regwrite, memwrite, iord;
    logic       memtoreg, regdst, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .irwrite(irwrite), .pcen(pcen),
        .regwrite(regwrite), .memwrite(memwrite), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .illegal(illegal), .state(state)
    );

    // w: irwrite,pcen,regwrite,memwrite,iord,memtoreg,regdst,alusrca
    function automatic logic [18:0] e(input logic [3:0] st,
                                      input logic [7:0] w,
                                      input logic [1:0] b,
                                      input logic [1:0] p,
                                      input logic [1:0] a,
                                      input logic il);
        return {st, w, b, p, a, il};
    endfunction

    // Drive one cycle of inputs and queue that cycle's expected outputs.
    task automatic cyc(input string nm, input logic [3:0] op,
                       input logic z, input logic mr, input logic rst,
                       input logic [18:0] ex);
        @(posedge clk);
        #1;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        reset     = rst;
        exp_q.push_back(ex);
        name_q.push_back(nm);
    endtask

    // Monitor: compare outputs mid-cycle against the scoreboard head.
    always @(negedge clk) begin
        logic [18:0] got, want;
        string nm;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {state, irwrite, pcen, regwrite, memwrite, iord,
                    memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop,
                    illegal};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s: got=%b required=%b", nm, got, want);
            end
        end
    end

    localparam logic [18:0] F_OK = 19'b0000_11000000_01_00_11_0;
    localparam logic [18:0] F_ST = 19'b0000_00000000_01_00_11_0;
    localparam logic [18:0] D_OK = 19'b0001_00000000_11_00_11_0;
    localparam logic [18:0] MADR = 19'b0010_00000001_10_00_11_0;
    localparam logic [18:0] MWR  = 19'b0101_00011000_00_00_11_0;

    initial begin
        cyc("reset0", 4'd0, 1'b0, 1'b1, 1'b1, e(4'd0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0));
        cyc("reset1", 4'd0, 1'b0, 1'b1, 1'b1, e(4'd0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0));

        // lw, opcode changed late to show it is ignored
        cyc("lw_fetch",  4'd1, 1'b0, 1'b1, 1'b0, F_OK);
        cyc("lw_decode", 4'd1, 1'b0, 1'b1, 1'b0, D_OK);
        cyc("lw_memadr", 4'd1, 1'b0, 1'b1, 1'b0, MADR);
        cyc("lw_memrd",  4'd6, 1'b0, 1'b1, 1'b0, e(4'd3, 8'b0000_1000, 2'b00, 2'b00, 2'b11, 1'b0));
        cyc("lw_memwb",  4'd6, 1'b0, 1'b1, 1'b0, e(4'd4, 8'b0010_0100, 2'b00, 2'b00, 2'b11, 1'b0));

        // R-type
        cyc("r_fetch",   4'd0, 1'b0, 1'b1, 1'b0, F_OK);
        cyc("r_decode",  4'd0, 1'b0, 1'b1, 1'b0, D_OK);
        cyc("r_execute", 4'd0, 1'b0, 1'b1, 1'b0, e(4'd6, 8'b0000_0001, 2'b00, 2'b00, 2'b00, 1'b0));
        cyc("r_aluwb",   4'd0, 1'b0, 1'b1, 1'b0, e(4'd7, 8'b0010_0010, 2'b00, 2'b00, 2'b11, 1'b0));

        // beq taken / not taken
        cyc("beq1_fetch",  4'd3, 1'b1, 1'b1, 1'b0, F_OK);
        cyc("beq1_decode", 4'd3, 1'b1, 1'b1, 1'b0, D_OK);
        cyc("beq1_branch", 4'd3, 1'b1, 1'b1, 1'b0, e(4'd8, 8'b0100_0001, 2'b00, 2'b01, 2'b10, 1'b0));
        cyc("beq0_fetch",  4'd3, 1'b0, 1'b1, 1'b0, F_OK);
        cyc("beq0_decode", 4'd3, 1'b0, 1'b1, 1'b0, D_OK);
        cyc("beq0_branch", 4'd3, 1'b0, 1'b1, 1'b0, e(4'd8, 8'b0000_0001, 2'b00, 2'b01, 2'b10, 1'b0));

        // sw with a fetch stall and three store stalls
        cyc("sw_fstall",  4'd2, 1'b0, 1'b0, 1'b0, F_ST);
        cyc("sw_fetch",   4'd2, 1'b0, 1'b1, 1'b0, F_OK);
        cyc("sw_decode",  4'd2, 1'b0, 1'b1, 1'b0, D_OK);
        cyc("sw_memadr",  4'd2, 1'b0, 1'b1, 1'b0, MADR);
        cyc("sw_memwr0",  4'd2, 1'b0, 1'b0, 1'b0, MWR);
        cyc("sw_memwr1",  4'd2, 1'b0, 1'b0, 1'b0, MWR);
        cyc("sw_memwr2",  4'd2, 1'b0, 1'b0, 1'b0, MWR);
        cyc("sw_memwr3",  4'd2, 1'b0, 1'b1, 1'b0, MWR);

        // illegal opcode
        cyc("ill_fetch",  4'ha, 1'b0, 1'b1, 1'b0, F_OK);
        cyc("ill_decode", 4'ha, 1'b0, 1'b1, 1'b0, e(4'd1, 8'h00, 2'b11, 2'b00, 2'b11, 1'b1));

        // addi, slti, j
        cyc("addi_fetch",  4'd4, 1'b0, 1'b1, 1'b0, F_OK);
        cyc("addi_decode", 4'd4, 1'b0, 1'b1, 1'b0, D_OK);
        cyc("addi_ex",     4'd4, 1'b0, 1'b1, 1'b0, e(4'd9, 8'b0000_0001, 2'b10, 2'b00, 2'b11, 1'b0));
        cyc("addi_wb",     4'd4, 1'b0, 1'b1, 1'b0, e(4'd11, 8'b0010_0000, 2'b00, 2'b00, 2'b11, 1'b0));
        cyc("slti_fetch",  4'd5, 1'b0, 1'b1, 1'b0, F_OK);
        cyc("slti_decode", 4'd5, 1'b0, 1'b1, 1'b0, D_OK);
        cyc("slti_ex",     4'd5, 1'b0, 1'b1, 1'b0, e(4'd10, 8'b0000_0001, 2'b10, 2'b00, 2'b01, 1'b0));
        cyc("slti_wb",     4'd5, 1'b0, 1'b1, 1'b0, e(4'd11, 8'b0010_0000, 2'b00, 2'b00, 2'b11, 1'b0));
        cyc("j_fetch",     4'd6, 1'b0, 1'b1, 1'b0, F_OK);
        cyc("j_decode",    4'd6, 1'b0, 1'b1, 1'b0, D_OK);
        cyc("j_jump",      4'd6, 1'b0, 1'b1, 1'b0, e(4'd12, 8'b0100_0000, 2'b00, 2'b10, 2'b11, 1'b0));

        // reset during a MEMRD stall
        cyc("rs_fetch",  4'd1, 1'b0, 1'b1, 1'b0, F_OK);
        cyc("rs_decode", 4'd1, 1'b0, 1'b1, 1'b0, D_OK);
        cyc("rs_memadr", 4'd1, 1'b0, 1'b1, 1'b0, MADR);
        cyc("rs_stall",  4'd1, 1'b0, 1'b0, 1'b0, e(4'd3, 8'b0000_1000, 2'b00, 2'b00, 2'b11, 1'b0));
        cyc("rs_reset",  4'd1, 1'b0, 1'b1, 1'b1, e(4'd3, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0));
        cyc("rs_after",  4'd1, 1'b0, 1'b1, 1'b0, F_OK);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
